// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the mm:ss count-up stopwatch.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    FULL   = 2'd3
  } state_t;

  localparam logic [3:0] DIG_MAX_U = 4'd9;
  localparam logic [3:0] DIG_MAX_T = 4'd5;
  localparam logic [6:0] MAX_MIN   = 7'd99;
  localparam logic [6:0] MAX_SEC   = 7'd59;

  typedef struct packed {
    logic [3:0] mt;
    logic [3:0] mu;
    logic [3:0] st;
    logic [3:0] su;
  } bcd_t;

  function automatic logic [6:0] sat7(input logic [6:0] v, input logic [6:0] max);
    return (v > max) ? max : v;
  endfunction

  // Two BCD digits to binary as t*8 + t*2 + u, so limits never need a divider.
  function automatic logic [6:0] bcd2bin(input logic [3:0] t, input logic [3:0] u);
    return (7'(t) << 3) + (7'(t) << 1) + 7'(u);
  endfunction

endpackage

// File: rtl/sw_edge_det.sv
// Registered rising-edge pulse generator for one raw button level.
module sw_edge_det (
  input  logic clock,
  input  logic reset,
  input  logic btn,
  output logic pulse
);

  logic prev;

  always_ff @(posedge clock) begin
    if (!reset) begin
      prev  <= 1'b0;
      pulse <= 1'b0;
    end else begin
      prev  <= btn;
      pulse <= btn & ~prev;
    end
  end

endmodule

// File: rtl/stopwatch.sv
// Count-up mm:ss stopwatch with start/pause/stop/lap and a programmable limit.
// Defining STOPWATCH_LAP_EN builds the lap capture register and display mux.
module stopwatch
  import stopwatch_pkg::*;
#(
  parameter int TICK_CONT = 100000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       pause,
  input  logic       stop,
  input  logic       lap,
  input  logic [6:0] lim_min,
  input  logic [6:0] lim_sec,
  output logic [5:0] d1,
  output logic [5:0] d2,
  output logic [5:0] d3,
  output logic [5:0] d4,
  output logic       running,
  output logic       done,
  output logic       tick
);

  localparam int            PW         = $clog2(TICK_CONT);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CONT - 1);

  state_t        state, state_nxt;
  logic [PW-1:0] presc;
  bcd_t          cnt, cnt_inc, cnt_d, view, disp;
  logic [6:0]    lim_min_s, lim_sec_s, lim_min_q, lim_sec_q;
  logic          start_p, pause_p, stop_p, lap_p;
  logic          wrap, adv, inc, hit, fresh;

  sw_edge_det u_start (.clock(clock), .reset(reset), .btn(start), .pulse(start_p));
  sw_edge_det u_pause (.clock(clock), .reset(reset), .btn(pause), .pulse(pause_p));
  sw_edge_det u_stop  (.clock(clock), .reset(reset), .btn(stop),  .pulse(stop_p));
  sw_edge_det u_lap   (.clock(clock), .reset(reset), .btn(lap),   .pulse(lap_p));

  assign wrap  = (presc == PRESC_LAST);
  assign adv   = (state == RUN) && !stop_p && !pause_p;
  assign inc   = adv && wrap;
  assign fresh = ((state == IDLE) || (state == FULL)) && (state_nxt == RUN);

  // A zero limit means the full 99:59 range.
  always_comb begin
    lim_min_s = sat7(lim_min, MAX_MIN);
    lim_sec_s = sat7(lim_sec, MAX_SEC);
    if ((lim_min_s == 7'd0) && (lim_sec_s == 7'd0)) begin
      lim_min_s = MAX_MIN;
      lim_sec_s = MAX_SEC;
    end
  end

  always_ff @(posedge clock) begin
    if (fresh) begin
      lim_min_q <= lim_min_s;
      lim_sec_q <= lim_sec_s;
    end
  end

  always_comb begin
    cnt_inc = cnt;
    if (cnt.su != DIG_MAX_U) begin
      cnt_inc.su = cnt.su + 4'd1;
    end else begin
      cnt_inc.su = 4'd0;
      if (cnt.st != DIG_MAX_T) begin
        cnt_inc.st = cnt.st + 4'd1;
      end else begin
        cnt_inc.st = 4'd0;
        if (cnt.mu != DIG_MAX_U) begin
          cnt_inc.mu = cnt.mu + 4'd1;
        end else begin
          cnt_inc.mu = 4'd0;
          cnt_inc.mt = cnt.mt + 4'd1;
        end
      end
    end
  end

  assign hit = (bcd2bin(cnt_inc.mt, cnt_inc.mu) == lim_min_q) &&
               (bcd2bin(cnt_inc.st, cnt_inc.su) == lim_sec_q);

  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:   if (!stop_p && start_p) state_nxt = RUN;
      RUN:    if (stop_p)                  state_nxt = IDLE;
              else if (pause_p)            state_nxt = PAUSED;
              else if (inc && hit)         state_nxt = FULL;
      PAUSED: if (stop_p)                  state_nxt = IDLE;
              else if (pause_p || start_p) state_nxt = RUN;
      FULL:   if (stop_p)                  state_nxt = IDLE;
              else if (start_p)            state_nxt = RUN;
    endcase
  end

  always_comb begin
    running = (state == RUN);
    done    = (state == FULL);
    tick    = inc;
  end

  always_ff @(posedge clock) begin
    if (!reset)                   presc <= '0;
    else if (fresh)               presc <= '0;
    else if (state_nxt == IDLE)   presc <= '0;
    else if (adv)                 presc <= wrap ? '0 : presc + PW'(1);
  end

  always_comb begin
    cnt_d = cnt;
    if (fresh)    cnt_d = '0;
    else if (inc) cnt_d = cnt_inc;
  end

`ifdef STOPWATCH_LAP_EN
  bcd_t lap_q, lap_d;
  logic hold, hold_d, lap_take;

  assign lap_take = lap_p && !stop_p && !pause_p && !start_p;

  always_comb begin
    hold_d = hold;
    lap_d  = lap_q;
    if ((state_nxt == IDLE) || fresh) begin
      hold_d = 1'b0;
    end else if (lap_take) begin
      if (hold) begin
        hold_d = 1'b0;
      end else if (state == RUN) begin
        hold_d = 1'b1;
        lap_d  = cnt;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) hold <= 1'b0;
    else        hold <= hold_d;
    lap_q <= lap_d;
  end

  assign view = hold_d ? lap_d : cnt_d;
`else
  logic unused_lap_p;
  assign unused_lap_p = lap_p;
  assign view = cnt_d;
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt  <= '0;
      disp <= '0;
    end else begin
      cnt  <= cnt_d;
      disp <= view;
    end
  end

  assign d1 = {1'b1, disp.su, 1'b0};
  assign d2 = {1'b1, disp.st, 1'b0};
  assign d3 = {1'b1, disp.mu, 1'b0};
  assign d4 = {1'b1, disp.mt, 1'b0};

endmodule
